// File: rtl/uart_pkg.sv
// uart_pkg: shared types and frame-format helpers for the UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  typedef enum logic [1:0] {WLS_5, WLS_6, WLS_7, WLS_8} wls_t;
  function automatic logic parity_calc(input logic [7:0] data, input logic [1:0] wls, input logic eps, input logic sticky);
    logic [7:0] mask;
    mask = 8'hff >> (2'd3 - wls);
    return sticky ? ~eps : (^(data & mask)) ^ ~eps;
  endfunction
  function automatic int stop_ticks(input logic stb, input logic [1:0] wls, input int os);
    return !stb ? os : (wls == WLS_5 ? os + os / 2 : 2 * os);
  endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: THR write path and LSR status between register file and transmitter.
interface uart_tx_fifo_if #(parameter int FIFO_DEPTH = 16);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic wr_en;
  logic [7:0] wr_data;
  logic wr_drop;
  logic thre;
  logic temt;
  logic [CW-1:0] fifo_count;
  modport master (output wr_en, wr_data, input wr_drop, thre, temt, fifo_count);
  modport slave (input wr_en, wr_data, output wr_drop, thre, temt, fifo_count);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with occupancy count and synchronous clear.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW + 1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !clear) mem[wp] <= din;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 16550-style transmitter with TX FIFO and oversampled bit timing.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        baud_pulse,
  input  logic        fifo_en,
  input  logic        fifo_clr,
  input  logic [1:0]  wls,
  input  logic        stb,
  input  logic        pen,
  input  logic        eps,
  input  logic        sticky_parity,
  input  logic        set_break,
  output logic        tx,
  uart_tx_fifo_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(2 * OVERSAMPLE + 1);
  tx_state_t state, state_d;
  logic [TW-1:0] tick, tick_d, stop_len, len;
  logic [2:0] bit_cnt, bit_d;
  logic [7:0] sh, sh_d, head;
  logic [1:0] wls_q;
  logic [CW-1:0] count;
  logic pen_q, par_q, fifo_en_q, tx_d, last, load, clear, full, empty, full_eff, push;
  // A mode change flushes the queue exactly like an explicit clear.
  assign clear = fifo_clr || (fifo_en != fifo_en_q);
  assign full_eff = fifo_en ? full : !empty;
  assign push = bus.wr_en && !clear && (!full_eff || load);
  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(load), .clear(clear),
    .din(bus.wr_data), .dout(head), .count(count), .full(full), .empty(empty)
  );
  assign bus.fifo_count = count;
  assign bus.thre = empty;
  assign bus.temt = empty && state == IDLE;
  always_comb begin
    len = state == STOP ? stop_len : TW'(OVERSAMPLE);
    last = baud_pulse && tick == len - TW'(1);
    load = !empty && (state == IDLE || (state == STOP && last));
    tick_d = (state == IDLE || last) ? '0 : tick + TW'(baud_pulse);
    bit_d = state == DATA ? bit_cnt + 3'(last) : '0;
    sh_d = load ? head : (state == DATA && last) ? sh >> 1 : sh;
    state_d = state;
    case (state)
      IDLE:    if (load) state_d = START;
      START:   if (last) state_d = DATA;
      DATA:    if (last && bit_cnt == 3'd4 + 3'(wls_q)) state_d = pen_q ? PARITY : STOP;
      PARITY:  if (last) state_d = STOP;
      STOP:    if (last) state_d = load ? START : IDLE;
      default: state_d = IDLE;
    endcase
    // tx is registered from the next-state view so it changes with the state.
    tx_d = set_break ? 1'b0 : state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] :
           state_d == PARITY ? par_q : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tick <= '0;
      bit_cnt <= '0;
      sh <= '0;
      wls_q <= '0;
      pen_q <= 1'b0;
      par_q <= 1'b0;
      stop_len <= TW'(OVERSAMPLE);
      fifo_en_q <= 1'b0;
      tx <= 1'b1;
      bus.wr_drop <= 1'b0;
    end else begin
      state <= state_d;
      tick <= tick_d;
      bit_cnt <= bit_d;
      sh <= sh_d;
      fifo_en_q <= fifo_en;
      tx <= tx_d;
      bus.wr_drop <= bus.wr_en && !clear && full_eff && !load;
      if (load) begin
        wls_q <= wls;
        pen_q <= pen;
        par_q <= parity_calc(head, wls, eps, sticky_parity);
        stop_len <= TW'(stop_ticks(stb, wls, OVERSAMPLE));
      end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench comparing tx tick streams to a frame model.
module tb_uart_tx_fifo;
  localparam int OS = 16;
  logic clk = 0, rst_n = 0, baud_pulse = 0, fifo_en = 1, fifo_clr = 0;
  logic stb = 0, pen = 0, eps = 0, sticky_parity = 0, set_break = 0, tx;
  logic [1:0] wls = 2'b11;
  int checks = 0, errors = 0, consumed = 0;
  bit ticks[$];
  bit exp_q[$];
  uart_tx_fifo_if #(.FIFO_DEPTH(4)) bus();
  uart_tx_fifo #(.FIFO_DEPTH(4), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .baud_pulse(baud_pulse), .fifo_en(fifo_en), .fifo_clr(fifo_clr),
    .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sticky_parity(sticky_parity),
    .set_break(set_break), .tx(tx), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (baud_pulse) consumed <= consumed + 1;
  // Each sample is the tx level during the baud tick that the next edge consumes.
  initial forever begin
    @(negedge clk);
    baud_pulse = 1'($urandom_range(0, 1));
    if (baud_pulse) ticks.push_back(tx);
  end

  task tick(); @(negedge clk); #1; endtask
  task put(input logic [7:0] d); tick(); bus.wr_en = 1; bus.wr_data = d; endtask
  task rel(); tick(); bus.wr_en = 0; endtask
  task add_frame(input logic [7:0] d);
    int nb;
    bit p;
    nb = int'(wls) + 5;
    p = 0;
    for (int i = 0; i < nb; i++) p ^= d[i];
    p = sticky_parity ? !eps : (eps ? p : !p);
    repeat (OS) exp_q.push_back(0);
    for (int i = 0; i < nb; i++) repeat (OS) exp_q.push_back(d[i]);
    if (pen) repeat (OS) exp_q.push_back(p);
    repeat (!stb ? OS : (wls == 2'b00 ? OS * 3 / 2 : 2 * OS)) exp_q.push_back(1);
  endtask
  task launch(input logic [7:0] d, output int c0);
    add_frame(d);
    put(d);
    rel();
    tick();
    c0 = consumed;
  endtask
  task wait_temt(output bit ok);
    ok = 0;
    for (int k = 0; k < 20000; k++) begin
      tick();
      if (bus.temt) begin ok = 1; break; end
    end
  endtask
  task fresh(); ticks.delete(); exp_q.delete(); endtask
  function automatic int first_zero();
    for (int i = 0; i < ticks.size(); i++) if (!ticks[i]) return i;
    return -1;
  endfunction
  function automatic int stream_diff();
    int s;
    s = first_zero();
    if (s < 0) return 0;
    for (int j = 0; j < exp_q.size(); j++)
      if (s + j >= ticks.size() || ticks[s + j] != exp_q[j]) return j;
    for (int j = s + exp_q.size(); j < ticks.size(); j++) if (!ticks[j]) return j - s;
    return -1;
  endfunction

  task test_reset();
    bus.wr_en = 0; bus.wr_data = 0;
    repeat (3) tick();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (bus.thre !== 1'b1) begin errors++; $display("FAIL reset_thre got=%b exp=1", bus.thre); end
    checks++; if (bus.temt !== 1'b1) begin errors++; $display("FAIL reset_temt got=%b exp=1", bus.temt); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.fifo_count); end
    checks++; if (bus.wr_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", bus.wr_drop); end
    rst_n = 1;
    repeat (4) tick();
  endtask

  task test_8e2();
    int c0, d;
    bit ok;
    wls = 2'b11; pen = 1; eps = 1; stb = 1; sticky_parity = 0;
    fresh();
    add_frame(8'h13);
    put(8'h13);
    rel();
    checks++; if (bus.fifo_count !== 3'd1 || tx !== 1'b1) begin errors++; $display("FAIL 8e2_after_write count=%0d tx=%b exp count=1 tx=1", bus.fifo_count, tx); end
    tick();
    checks++; if (tx !== 1'b0 || bus.fifo_count !== 3'd0 || bus.thre !== 1'b1) begin errors++; $display("FAIL 8e2_start tx=%b count=%0d thre=%b exp 0,0,1", tx, bus.fifo_count, bus.thre); end
    c0 = consumed;
    wait_temt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL 8e2_temt_timeout got=0 exp=1"); end
    checks++; if (consumed - c0 !== 192) begin errors++; $display("FAIL 8e2_length got=%0d exp=192", consumed - c0); end
    d = stream_diff();
    checks++; if (d !== -1) begin errors++; $display("FAIL 8e2_stream first_bad_tick=%0d exp=-1", d); end
  endtask

  task test_5bit();
    int c0, d;
    bit ok;
    wls = 2'b00; pen = 0; eps = 0; stb = 1; sticky_parity = 0;
    fresh();
    launch(8'h1F, c0);
    wait_temt(ok);
    checks++; if (!ok || consumed - c0 !== 120) begin errors++; $display("FAIL 5bit_length got=%0d ok=%b exp=120", consumed - c0, ok); end
    d = stream_diff();
    checks++; if (d !== -1) begin errors++; $display("FAIL 5bit_stream first_bad_tick=%0d exp=-1", d); end
  endtask

  task test_back_to_back();
    logic [7:0] dat [6];
    int c0, d, ec;
    bit ok;
    wls = 2'($urandom); pen = 1'($urandom); eps = 1'($urandom); stb = 1'($urandom); sticky_parity = 0;
    foreach (dat[i]) dat[i] = 8'($urandom);
    fresh();
    for (int i = 0; i < 5; i++) add_frame(dat[i]);
    c0 = 0;
    for (int i = 0; i < 6; i++) begin
      put(dat[i]);
      if (i == 2) c0 = consumed;
      if (i > 0) begin
        ec = (i - 1 == 0) ? 1 : i - 1;
        checks++; if (bus.fifo_count !== 3'(ec) || bus.wr_drop !== 1'b0) begin errors++; $display("FAIL b2b_count_w%0d count=%0d drop=%b exp count=%0d drop=0", i - 1, bus.fifo_count, bus.wr_drop, ec); end
      end
    end
    rel();
    checks++; if (bus.wr_drop !== 1'b1 || bus.fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_drop drop=%b count=%0d exp drop=1 count=4", bus.wr_drop, bus.fifo_count); end
    tick();
    checks++; if (bus.wr_drop !== 1'b0) begin errors++; $display("FAIL b2b_drop_pulse got=%b exp=0", bus.wr_drop); end
    wait_temt(ok);
    checks++; if (!ok || consumed - c0 !== exp_q.size()) begin errors++; $display("FAIL b2b_length got=%0d exp=%0d", consumed - c0, exp_q.size()); end
    d = stream_diff();
    checks++; if (d !== -1) begin errors++; $display("FAIL b2b_stream first_bad_tick=%0d exp=-1", d); end
  endtask

  task test_sticky();
    int c0, d, s;
    bit ok;
    wls = 2'b11; pen = 1; eps = 0; stb = 0; sticky_parity = 1;
    fresh();
    add_frame(8'h00);
    add_frame(8'hFF);
    put(8'h00);
    put(8'hFF);
    rel();
    c0 = consumed;
    wait_temt(ok);
    checks++; if (!ok || consumed - c0 !== exp_q.size()) begin errors++; $display("FAIL sticky_length got=%0d exp=%0d", consumed - c0, exp_q.size()); end
    d = stream_diff();
    checks++; if (d !== -1) begin errors++; $display("FAIL sticky_stream first_bad_tick=%0d exp=-1", d); end
    s = first_zero() + 9 * OS + OS / 2;
    for (int f = 0; f < 2; f++) begin
      checks++;
      if (s < 0 || s + f * 11 * OS >= ticks.size() || ticks[s + f * 11 * OS] !== 1'b1) begin
        errors++; $display("FAIL sticky_parity_f%0d got=%b exp=1", f, (s >= 0 && s + f * 11 * OS < ticks.size()) ? ticks[s + f * 11 * OS] : 1'b0);
      end
    end
    sticky_parity = 0;
  endtask

  task test_nonfifo();
    int c0, d;
    bit ok;
    fifo_en = 0; wls = 2'b11; pen = 0; stb = 0; sticky_parity = 0;
    repeat (3) tick();
    fresh();
    launch(8'h11, c0);
    put(8'hA5);
    put(8'h5A);
    checks++; if (bus.fifo_count !== 3'd1 || bus.wr_drop !== 1'b0) begin errors++; $display("FAIL nf_first count=%0d drop=%b exp count=1 drop=0", bus.fifo_count, bus.wr_drop); end
    rel();
    checks++; if (bus.fifo_count !== 3'd1 || bus.wr_drop !== 1'b1) begin errors++; $display("FAIL nf_second count=%0d drop=%b exp count=1 drop=1", bus.fifo_count, bus.wr_drop); end
    tick();
    fifo_clr = 1;
    tick();
    fifo_clr = 0;
    checks++; if (bus.fifo_count !== 3'd0 || bus.thre !== 1'b1 || bus.temt !== 1'b0) begin errors++; $display("FAIL nf_clear count=%0d thre=%b temt=%b exp 0,1,0", bus.fifo_count, bus.thre, bus.temt); end
    wait_temt(ok);
    checks++; if (!ok || consumed - c0 !== 160) begin errors++; $display("FAIL nf_length got=%0d exp=160", consumed - c0); end
    d = stream_diff();
    checks++; if (d !== -1) begin errors++; $display("FAIL nf_stream first_bad_tick=%0d exp=-1", d); end
    fifo_en = 1;
    repeat (3) tick();
  endtask

  task test_random();
    int c0, d;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      wls = 2'($urandom); pen = 1'($urandom); eps = 1'($urandom); stb = 1'($urandom); sticky_parity = 1'($urandom);
      fresh();
      launch(8'($urandom), c0);
      wls = 2'($urandom); pen = 1'($urandom); eps = 1'($urandom); stb = 1'($urandom); sticky_parity = 1'($urandom);
      wait_temt(ok);
      checks++; if (!ok || consumed - c0 !== exp_q.size()) begin errors++; $display("FAIL rand%0d_length got=%0d exp=%0d", it, consumed - c0, exp_q.size()); end
      d = stream_diff();
      checks++; if (d !== -1) begin errors++; $display("FAIL rand%0d_stream first_bad_tick=%0d exp=-1", it, d); end
    end
    sticky_parity = 0;
  endtask

  task test_break();
    int c0, bad;
    bit ok;
    wls = 2'b11; pen = 0; stb = 0; sticky_parity = 0;
    fresh();
    launch(8'h55, c0);
    for (int k = 0; k < 5000 && consumed - c0 < 20; k++) tick();
    set_break = 1;
    tick();
    bad = 0;
    for (int k = 0; k < 5000 && consumed - c0 < 20 + 3 * OS; k++) begin
      if (tx !== 1'b0) bad++;
      tick();
    end
    set_break = 0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL break_low high_cycles=%0d exp=0", bad); end
    checks++; if (bus.temt !== 1'b0) begin errors++; $display("FAIL break_busy temt=%b exp=0", bus.temt); end
    wait_temt(ok);
    checks++; if (!ok || consumed - c0 !== 160) begin errors++; $display("FAIL break_length got=%0d exp=160", consumed - c0); end
  endtask

  task test_reset_mid();
    int c0;
    wls = 2'b11; pen = 0; stb = 0;
    fresh();
    put(8'h3C);
    put(8'hC3);
    rel();
    c0 = consumed;
    tick();
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL rst_pre_count got=%0d exp=1", bus.fifo_count); end
    for (int k = 0; k < 5000 && consumed - c0 < 40; k++) tick();
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_pre_tx got=%b exp=0", tx); end
    #2 rst_n = 0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_async_tx got=%b exp=1", tx); end
    checks++; if (bus.thre !== 1'b1 || bus.temt !== 1'b1) begin errors++; $display("FAIL rst_async_flags thre=%b temt=%b exp 1,1", bus.thre, bus.temt); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rst_async_count got=%0d exp=0", bus.fifo_count); end
    @(negedge clk);
    rst_n = 1;
    repeat (4) tick();
    checks++; if (tx !== 1'b1 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rst_after tx=%b count=%0d exp 1,0", tx, bus.fifo_count); end
  endtask

  initial begin
    test_reset();
    test_8e2();
    test_5bit();
    test_back_to_back();
    test_sticky();
    test_nonfifo();
    test_random();
    test_break();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised 16550-style UART transmitter with an integrated transmit FIFO and oversampled bit timing. It generalises the single-holding-register transmitter: a configurable-depth FIFO, 16550 FIFO/non-FIFO modes, FIFO clear, write-drop flagging, and bit periods counted in baud ticks (`OVERSAMPLE` ticks per bit) instead of one tick per bit. It sits between the register-file write path (THR writes) and the `tx` pin, and feeds LSR status (`thre`, `temt`).

## Interface
Parameters:
- `FIFO_DEPTH`, default 16, TX FIFO entries; power of two, ≥2.
- `OVERSAMPLE`, default 16, `baud_pulse` ticks per bit; ≥2, even.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `baud_pulse`  in  1  one-cycle strobe at OVERSAMPLE×baud.
- `wr_en`  in  1  THR write strobe.
- `wr_data`  in  8  THR write data.
- `fifo_en`  in  1  1: FIFO mode; 0: 1-entry holding register.
- `fifo_clr`  in  1  one-cycle FIFO flush.
- `wls`  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
- `stb`  in  1  0: 1 stop bit; 1: 1.5 stop bits (wls=00), else 2.
- `pen`  in  1  parity enable.
- `eps`  in  1  1: even, 0: odd parity.
- `sticky_parity`  in  1  parity bit forced to `~eps`.
- `set_break`  in  1  force `tx` low.
- `thre`  out  1  FIFO/holding register empty.
- `temt`  out  1  FIFO empty and shifter idle.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `wr_drop`  out  1  one-cycle pulse: write discarded (full).
- `tx`  out  1  serial output.

## Operation
- Reset values: `tx`=1, `thre`=1, `temt`=1, `fifo_count`=0, `wr_drop`=0, FSM=IDLE, pointers and tick counter 0.
- Capacity: `FIFO_DEPTH` when `fifo_en`=1, else 1. Full = count==capacity.
- Write: accepted if not full, or if a pop occurs in the same cycle. Otherwise dropped, `wr_drop`=1 for one cycle.
- `fifo_clr`: count and pointers go to 0 next cycle. A same-cycle write is discarded without `wr_drop`. The frame in progress completes.
- Toggling `fifo_en` flushes the FIFO as for `fifo_clr`.
- FSM states: IDLE→START→DATA→(PARITY if pen)→STOP→IDLE, or →START directly if the FIFO is non-empty at the end of STOP.
- Load, in IDLE or at the end of STOP with count>0: pop the head entry, latch data, `wls`, `pen`, `eps`, `sticky_parity` and `stb`. Config changes mid-frame do not affect the current frame.
- Tick counter counts `baud_pulse` in each state. The state advances when count reaches the bit length: `OVERSAMPLE` per bit; STOP lasts 1, 1.5 or 2 × `OVERSAMPLE`.
- DATA: LSB first, `wls`+5 bits. Unused upper data bits are ignored.
- Parity bit:
  - `sticky_parity`=1: `~eps`.
  - Otherwise `eps`=1: XOR of the valid data bits.
  - `eps`=0: inverted XOR.
- `tx`: START=0, DATA=bit, PARITY=p, STOP/IDLE=1, all registered. `set_break`=1 forces `tx`=0; the FSM continues, and the frame is lost.
- `thre` = count==0 (combinational from registered count). `temt` = `thre` && state==IDLE.

## Timing
- Write to `fifo_count` update: 1 cycle.
- Idle with empty FIFO, write at cycle N: pop at N+1, `tx` falls at N+2.
- Frame length = (1 + wls+5 + pen + stop) × `OVERSAMPLE` `baud_pulse` ticks. Stop = 1, 1.5 or 2 bits.
- Back-to-back frames: no idle bit. The next START begins the cycle after the last STOP tick.
- `thre` rises the cycle after the pop that empties the FIFO. `temt` rises the cycle after the final STOP tick.
- Write and pop in the same cycle at full: both occur, count unchanged.
- `rst_n` asserted mid-frame: `tx`=1 immediately (asynchronous), FIFO emptied.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` enum.
  - `wls` encodings.
  - function `parity_calc(data, wls, eps, sticky)`.
  - function `stop_ticks(stb, wls, OVERSAMPLE)`.
- Sub-module `uart_sync_fifo`, parametrised by depth and width. Outputs: count, full, empty. Inputs: push, pop, clear.
- Top level: FSM, tick counter, bit counter, shift register.

## Test plan
- `OVERSAMPLE`=16, 8E2 (`wls`=11, `pen`=1, `eps`=1, `stb`=1), write 0x13 → `tx` sequence 0,1,1,0,0,1,0,0,0,1,1,1, each bit held 16 ticks (192 ticks total); `temt` rises after the final tick.
- 5-bit, `stb`=1, `pen`=0, write 0x1F → start, five 1s, then 24-tick stop.
- `FIFO_DEPTH`=4, five back-to-back writes while idle → count 1→4 (one entry popped immediately), fifth write accepted, then a sixth write gives `wr_drop`=1; frames stream out with no idle gap.
- `sticky_parity`=1, `eps`=0, data 0x00 and 0xFF → parity bit 1 in both frames.
- `fifo_en`=0, write 0xA5 then 0x5A in consecutive cycles while a frame is active → second write accepted only if the holding register is empty, else `wr_drop`. A later `fifo_clr` empties it without aborting the active frame.
- `set_break` for 3 bit times mid-frame → `tx`=0 throughout, FSM completes. Then `rst_n` low mid-frame → `tx`=1, `thre`=`temt`=1, `fifo_count`=0 asynchronously.
